// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands serially, one 4-bit nibble per clock, LSB
//   nibble first. The nibble addition is done by an external 4-bit
//   ripple-carry slice. This block drives the slice inputs, registers its
//   carry-out as the next nibble's carry-in, and collects the sum nibbles.
//   The wide result is returned behind a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request            in_ready   block idle, can accept
//   a, b       WIDTH-bit operands         cin        carry into nibble 0
//   out_valid  result available           out_ready  consumer takes result
//   sum        (a+b+cin) mod 2^WIDTH      cout       carry out of the MSB
//   ovf        two's-complement overflow
//   rca_a/rca_b/rca_cin  to the slice (zero when not running)
//   rca_sum/rca_cout     from the slice, combinational in the same cycle
//
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       rca_a,
    output logic [3:0]       rca_b,
    output logic             rca_cin,
    input  logic [3:0]       rca_sum,
    input  logic             rca_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     count_q, count_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;

    logic              last_s;
    logic [WIDTH+3:0]  sum_cat_s;

    assign last_s = (count_q == CW'(NIB - 1));
    // New nibble enters at the top; after NIB shifts nibble 0 sits at the bottom.
    // Concatenating first keeps this legal even when WIDTH == 4.
    assign sum_cat_s = {rca_sum, sum_q};

    // Next-state and datapath update logic
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        count_d     = count_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    count_d = '0;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                sum_d   = sum_cat_s[WIDTH+3:4];
                carry_d = rca_cout;
                count_d = count_q + CW'(1);
                if (last_s) begin
                    cout_d      = rca_cout;
                    // Overflow: like-signed operands giving a result of the other sign.
                    ovf_d       = (sa_q == sb_q) && (rca_sum[3] != sa_q);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
        end
    end

    // Slice drive: live operand nibbles only while running, zero otherwise
    always_comb begin
        if (state_q == S_RUN) begin
            rca_a   = a_sh_q[3:0];
            rca_b   = b_sh_q[3:0];
            rca_cin = carry_q;
        end else begin
            rca_a   = 4'd0;
            rca_b   = 4'd0;
            rca_cin = 1'b0;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [3:0]       rca_a;
    logic [3:0]       rca_b;
    logic             rca_cin;
    logic [3:0]       rca_sum;
    logic             rca_cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit slice
    assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {4'd0, rca_cin};

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf),
        .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
        .rca_sum(rca_sum), .rca_cout(rca_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full add from IDLE; during 'hold' backpressure cycles a pending
    // request (pa,pb,pc) is presented and must not be taken.
    task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          input int hold, input logic [15:0] pa, input logic [15:0] pb,
                          input logic pc);
        int full;
        int mask;
        int exp_cin;
        logic exp_ovf;
        full    = int'(av) + int'(bv) + int'(cv);
        exp_ovf = (av[15] == bv[15]) && (full[15] != av[15]);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        for (int i = 0; i < NIB; i++) begin
            mask    = (1 << (4 * i)) - 1;
            exp_cin = (((int'(av) & mask) + (int'(bv) & mask) + int'(cv)) >> (4 * i)) & 1;
            chk("run_in_ready", {31'd0, in_ready}, 32'd0);
            chk("run_out_valid", {31'd0, out_valid}, 32'd0);
            chk("run_rca_a", {28'd0, rca_a}, (int'(av) >> (4 * i)) & 15);
            chk("run_rca_b", {28'd0, rca_b}, (int'(bv) >> (4 * i)) & 15);
            chk("run_rca_cin", {31'd0, rca_cin}, exp_cin);
            tick();
        end
        chk("done_out_valid", {31'd0, out_valid}, 32'd1);
        chk("done_sum", {16'd0, sum}, full & 32'hFFFF);
        chk("done_cout", {31'd0, cout}, (full >> 16) & 1);
        chk("done_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        chk("done_rca_a", {28'd0, rca_a}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            a = pa; b = pb; cin = pc; in_valid = 1'b1;
            tick();
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, full & 32'hFFFF);
            chk("hold_cout", {31'd0, cout}, (full >> 16) & 1);
            chk("hold_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_sum_kept", {16'd0, sum}, full & 32'hFFFF);
    endtask

    initial begin
        logic [15:0] ra[0:20];
        logic [15:0] rb[0:20];
        logic        rc[0:20];

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'h1234; b = 16'h4321; cin = 1'b1;

        // 1. reset with a request pending
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_rca", {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rel_out_valid", {31'd0, out_valid}, 32'd0);

        // 2..4. directed adds
        do_add(16'h1234, 16'h4321, 1'b0, 0, 16'h0, 16'h0, 1'b0);
        chk("t2_sum", {16'd0, sum}, 32'h5555);
        do_add(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0, 16'h0, 1'b0);
        chk("t3_cout", {31'd0, cout}, 32'd1);
        do_add(16'h7FFF, 16'h0000, 1'b1, 0, 16'h0, 16'h0, 1'b0);
        chk("t4a_ovf", {31'd0, ovf}, 32'd1);
        do_add(16'h8000, 16'h8000, 1'b0, 0, 16'h0, 16'h0, 1'b0);
        chk("t4b_sum", {16'd0, sum}, 32'h0000);

        // 5. backpressure; pending request taken on the first IDLE edge
        do_add(16'h1111, 16'h2222, 1'b0, 5, 16'hABCD, 16'h1357, 1'b1);
        do_add(16'hABCD, 16'h1357, 1'b1, 0, 16'h0, 16'h0, 1'b0);

        // 6. reset on the second RUN edge
        a = 16'h5A5A; b = 16'hA5A5; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        chk("mid_rst_rca", {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        do_add(16'h00FF, 16'h0F01, 1'b0, 0, 16'h0, 16'h0, 1'b0);
        chk("t6_sum", {16'd0, sum}, 32'h1000);

        // random adds with random backpressure
        for (int k = 0; k <= 20; k++) begin
            ra[k] = 16'($urandom);
            rb[k] = 16'($urandom);
            rc[k] = 1'($urandom);
        end
        for (int k = 0; k < 20; k++) begin
            do_add(ra[k], rb[k], rc[k], (k == 19) ? 0 : int'($urandom_range(0, 2)),
                   ra[k+1], rb[k+1], rc[k+1]);
        end
        in_valid = 1'b0;
        tick();
        chk("end_in_ready", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequencer that feeds the team's 4-bit ripple-carry adder slice (rca) one nibble per clock to add WIDTH-bit operands serially, LSB nibble first. The slice carry-out is registered and fed back as the next nibble's carry-in. The block sits upstream of rca and drives its a/b/cin inputs through dedicated ports. It also consumes rca's sum/cout and assembles the wide result behind a valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4, derived localparam: number of RUN cycles per add

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a+b+cin modulo 2^WIDTH
cout  output  1  carry out of MSB
ovf  output  1  two's-complement overflow
rca_a  output  4  to rca.a
rca_b  output  4  to rca.b
rca_cin  output  1  to rca.cin
rca_sum  input  4  from rca.sum (combinational, same cycle)
rca_cout  input  1  from rca.cout

Behaviour:
- Interface: one clock clk; rst is synchronous, active-high; all state updates on rising clk.
- Reset (rst=1 at an edge, overrides everything): state=IDLE; a_sh, b_sh, sum, carry_r, count, cout, ovf, out_valid all 0. Reset applied mid-RUN or mid-DONE abandons the operation; no partial result is ever flagged valid.
- States:
  - IDLE: in_ready=1. An edge with in_valid=1 is the accept edge. At that edge: a_sh<=a, b_sh<=b, carry_r<=cin, count<=0, sa<=a[WIDTH-1], sb<=b[WIDTH-1], state<=RUN.
  - RUN: in_ready=0. Combinationally drive rca_a=a_sh[3:0], rca_b=b_sh[3:0], rca_cin=carry_r. Each edge:
    - a_sh and b_sh shift right by 4.
    - sum shifts right by 4 with rca_sum inserted at sum[WIDTH-1:WIDTH-4].
    - carry_r<=rca_cout; count<=count+1.
    - On the edge where count==NIB-1: cout<=rca_cout, ovf<=(sa==sb)&&(rca_sum[3]!=sa), out_valid<=1, state<=DONE.
  - DONE: out_valid=1; sum/cout/ovf held stable; in_ready=0. An edge with out_ready=1 sets out_valid<=0 and state<=IDLE. sum/cout/ovf retain their last values until the next completion.
- rca_a, rca_b and rca_cin are 0 in IDLE and DONE.
- Latency: out_valid is first high in the cycle after accept edge + NIB edges (4 cycles for WIDTH=16). Throughput: one add per NIB+2 cycles with out_ready held high.
- in_valid is ignored outside IDLE; operands are sampled only at the accept edge, so a/b may change afterwards.
- out_valid and in_ready are never high together. A new request presented in DONE is accepted at the first IDLE edge.
- Wrap-around: sum is modulo 2^WIDTH; the final carry goes only to cout.
- count width is clog2(NIB), minimum 1 bit.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0, rca_*=0; in_ready=1 after release; no operation starts during reset.
2. WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge. rca_a sequence is 4,3,2,1 and rca_b sequence is 1,2,3,4.
3. a=0xFFFF, b=0x0001, cin=0 -> rca_cin sequence 0,1,1,1; sum=0x0000, cout=1, ovf=0.
4. a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf stable, in_ready=0, a held in_valid is not accepted. Then out_ready=1 for one edge -> IDLE next cycle and the pending request is accepted on the following edge.
6. Reset mid-RUN: assert rst on the 2nd RUN edge -> IDLE and all outputs 0 next cycle. Then a=0x00FF, b=0x0F01, cin=0 -> sum=0x1000, cout=0, ovf=0.
